// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one 64-bit integer ALU between two
// requesters, one operation in flight at a time (IDLE -> EXEC -> RESP).
// Optional build macro: ALU_ARB_OPCHECK_EN -- illegal opcodes are not forwarded
// to the ALU and return result 0, zero 1, err 1.
module alu_share_arbiter #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned OPW   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req_x0,
   input  logic [WIDTH-1:0] req_x1,
   input  logic [WIDTH-1:0] req_y0,
   input  logic [WIDTH-1:0] req_y1,
   input  logic [OPW-1:0]   req_op0,
   input  logic [OPW-1:0]   req_op1,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   output logic [OPW-1:0]   alu_ctrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_grant_q, last_grant_d;
   logic [WIDTH-1:0] alu_x_q, alu_x_d;
   logic [WIDTH-1:0] alu_y_q, alu_y_d;
   logic [OPW-1:0]   alu_ctrl_q, alu_ctrl_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_zero_q, rsp_zero_d;

   logic             grant_any;
   logic             grant;
   logic [WIDTH-1:0] sel_x;
   logic [WIDTH-1:0] sel_y;
   logic [OPW-1:0]   sel_op;

`ifdef ALU_ARB_OPCHECK_EN
   logic             illegal_q, illegal_d;
   logic             rsp_err_q, rsp_err_d;
   logic             op_legal;
`endif

   // Round-robin pick: a lone requester wins, on a tie the one not served last
   always_comb begin
      grant_any = |req_valid;
      grant     = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
      sel_x     = grant ? req_x1  : req_x0;
      sel_y     = grant ? req_y1  : req_y0;
      sel_op    = grant ? req_op1 : req_op0;
`ifdef ALU_ARB_OPCHECK_EN
      op_legal  = (sel_op == OPW'(0)) || (sel_op == OPW'(1)) ||
                  (sel_op == OPW'(2)) || (sel_op == OPW'(6));
`endif
   end

   // Next-state, operand/response capture and request ready
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      alu_x_d      = alu_x_q;
      alu_y_d      = alu_y_q;
      alu_ctrl_d   = alu_ctrl_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      req_ready    = 2'b00;
`ifdef ALU_ARB_OPCHECK_EN
      illegal_d    = illegal_q;
      rsp_err_d    = rsp_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (grant_any) begin
               req_ready    = grant ? 2'b10 : 2'b01;
               owner_d      = grant;
               last_grant_d = grant;
               state_d      = ST_EXEC;
`ifdef ALU_ARB_OPCHECK_EN
               illegal_d    = ~op_legal;
               if (op_legal) begin
                  alu_x_d    = sel_x;
                  alu_y_d    = sel_y;
                  alu_ctrl_d = sel_op;
               end
`else
               alu_x_d      = sel_x;
               alu_y_d      = sel_y;
               alu_ctrl_d   = sel_op;
`endif
            end
         end
         ST_EXEC: begin
`ifdef ALU_ARB_OPCHECK_EN
            if (illegal_q) begin
               rsp_result_d = '0;
               rsp_zero_d   = 1'b1;
               rsp_err_d    = 1'b1;
            end else begin
               rsp_result_d = alu_result;
               rsp_zero_d   = alu_zero;
               rsp_err_d    = 1'b0;
            end
`else
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
`endif
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready[owner_q]) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         alu_x_q      <= '0;
         alu_y_q      <= '0;
         alu_ctrl_q   <= '0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
         illegal_q    <= 1'b0;
         rsp_err_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         alu_x_q      <= alu_x_d;
         alu_y_q      <= alu_y_d;
         alu_ctrl_q   <= alu_ctrl_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
`ifdef ALU_ARB_OPCHECK_EN
         illegal_q    <= illegal_d;
         rsp_err_q    <= rsp_err_d;
`endif
      end
   end

   // Outputs decoded straight from registered state
   always_comb begin
      rsp_valid  = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
      busy       = (state_q != ST_IDLE);
      rsp_result = rsp_result_q;
      rsp_zero   = rsp_zero_q;
      alu_x      = alu_x_q;
      alu_y      = alu_y_q;
      alu_ctrl   = alu_ctrl_q;
`ifdef ALU_ARB_OPCHECK_EN
      rsp_err    = rsp_err_q;
`else
      rsp_err    = 1'b0;
`endif
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural ALU.
// Build with ALU_ARB_OPCHECK_EN defined to cover the illegal-opcode path.
module tb_alu_share_arbiter;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned OPW   = 4;

   logic             clk;
   logic             rst_n;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [WIDTH-1:0] req_x0, req_x1, req_y0, req_y1;
   logic [OPW-1:0]   req_op0, req_op1;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_zero;
   logic             rsp_err;
   logic [WIDTH-1:0] alu_x, alu_y;
   logic [OPW-1:0]   alu_ctrl;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;
   logic             busy;

   int n_checks = 0;
   int n_errors = 0;

   alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_x0     (req_x0),
      .req_x1     (req_x1),
      .req_y0     (req_y0),
      .req_y1     (req_y1),
      .req_op0    (req_op0),
      .req_op1    (req_op1),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_err    (rsp_err),
      .alu_x      (alu_x),
      .alu_y      (alu_y),
      .alu_ctrl   (alu_ctrl),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural shared ALU
   always_comb begin
      case (alu_ctrl)
         4'd0:    alu_result = alu_x & alu_y;
         4'd1:    alu_result = alu_x | alu_y;
         4'd2:    alu_result = alu_x + alu_y;
         4'd6:    alu_result = alu_x - alu_y;
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request on port p, wait (bounded) for its grant, then drop valid
   task automatic issue(input int p, input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
      if (p == 0) begin
         req_x0 = x; req_y0 = y; req_op0 = op; req_valid[0] = 1'b1;
      end else begin
         req_x1 = x; req_y1 = y; req_op1 = op; req_valid[1] = 1'b1;
      end
      #1;
      for (int i = 0; i < 8 && !req_ready[p]; i++) step();
      check("issue_ready", 64'(req_ready[p]), 64'd1);
      step();
      req_valid[p] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      req_x0 = '0; req_x1 = '0; req_y0 = '0; req_y1 = '0;
      req_op0 = '0; req_op1 = '0;
      step();
      step();

      // Reset state
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
      check("rst_alu_x", alu_x, 64'd0);
      check("rst_rsp_result", rsp_result, 64'd0);
      check("rst_rsp_err", 64'(rsp_err), 64'd0);
      rst_n = 1'b1;
      step();

      // Single ADD on port 0: 5 + 7 = 12
      req_x0 = 64'd5; req_y0 = 64'd7; req_op0 = 4'd2; req_valid = 2'b01;
      #1;
      check("t1_req_ready", 64'(req_ready), 64'b01);
      step();
      req_valid = 2'b00;
      check("t1_alu_ctrl", 64'(alu_ctrl), 64'd2);
      check("t1_alu_x", alu_x, 64'd5);
      check("t1_busy", 64'(busy), 64'd1);
      check("t1_exec_no_rsp", 64'(rsp_valid), 64'd0);
      step();
      check("t1_rsp_valid", 64'(rsp_valid), 64'b01);
      check("t1_result", rsp_result, 64'd12);
      check("t1_zero", 64'(rsp_zero), 64'd0);
      check("t1_err", 64'(rsp_err), 64'd0);
      rsp_ready = 2'b01;
      step();
      rsp_ready = 2'b00;
      check("t1_rsp_drop", 64'(rsp_valid), 64'd0);
      check("t1_idle", 64'(busy), 64'd0);

      // Port 1 SUB equal operands, response held under back-pressure
      issue(1, 4'd6, 64'h1234, 64'h1234);
      step();
      req_x0 = 64'hF0; req_y0 = 64'h3C; req_op0 = 4'd0; req_valid = 2'b01;
      rsp_ready = 2'b01;   // non-owner ready must be ignored
      for (int i = 0; i < 4; i++) begin
         check("t2_hold_valid", 64'(rsp_valid), 64'b10);
         check("t2_hold_result", rsp_result, 64'd0);
         check("t2_hold_zero", 64'(rsp_zero), 64'd1);
         check("t2_hold_req_ready", 64'(req_ready), 64'd0);
         step();
      end
      rsp_ready = 2'b10;
      step();
      req_x1 = 64'hF0; req_y1 = 64'h0F; req_op1 = 4'd1;
      req_valid = 2'b11;
      rsp_ready = 2'b11;

      // Both ports valid: strict alternation starting with port 0
      for (int k = 0; k < 4; k++) begin
         int exp_p;
         exp_p = k % 2;
         #1;
         for (int i = 0; i < 8 && req_ready == 2'b00; i++) step();
         check("t3_grant", 64'(req_ready), (exp_p == 1) ? 64'b10 : 64'b01);
         step();
         step();
         check("t3_rsp_valid", 64'(rsp_valid), (exp_p == 1) ? 64'b10 : 64'b01);
         check("t3_result", rsp_result, (exp_p == 1) ? 64'hFF : 64'h30);
         step();
      end
      req_valid = 2'b00;
      rsp_ready = 2'b00;

      // Wrap-around ADD, then reset during its response
      issue(0, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      step();
      check("t4_rsp_valid", 64'(rsp_valid), 64'b01);
      check("t4_wrap_result", rsp_result, 64'd0);
      check("t4_wrap_zero", 64'(rsp_zero), 64'd1);
      rst_n = 1'b0;
      #1;
      check("t4_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("t4_rst_busy", 64'(busy), 64'd0);
      check("t4_rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
      check("t4_rst_alu_x", alu_x, 64'd0);
      check("t4_rst_result", rsp_result, 64'd0);
      step();
      rst_n = 1'b1;
      req_x1 = 64'd10; req_y1 = 64'd3; req_op1 = 4'd6;
      req_valid = 2'b11;
      #1;
      check("t4_first_grant", 64'(req_ready), 64'b01);
      step();
      req_valid[0] = 1'b0;
      step();
      check("t4_rsp0_valid", 64'(rsp_valid), 64'b01);
      check("t4_rsp0_result", rsp_result, 64'd0);
      check("t4_rsp0_zero", 64'(rsp_zero), 64'd1);
      rsp_ready = 2'b01;
      step();
      rsp_ready = 2'b00;
      check("t4_second_grant", 64'(req_ready), 64'b10);
      step();
      req_valid = 2'b00;
      check("t4_alu_x1", alu_x, 64'd10);
      step();
      check("t4_rsp1_valid", 64'(rsp_valid), 64'b10);
      check("t4_rsp1_result", rsp_result, 64'd7);
      check("t4_rsp1_zero", 64'(rsp_zero), 64'd0);
      rsp_ready = 2'b10;
      step();
      rsp_ready = 2'b00;

      // Unsupported opcode 3 on port 0 (alu_ctrl currently 6)
      issue(0, 4'd3, 64'd9, 64'd9);
`ifdef ALU_ARB_OPCHECK_EN
      check("t5_alu_ctrl_kept", 64'(alu_ctrl), 64'd6);
      check("t5_alu_x_kept", alu_x, 64'd10);
`else
      check("t5_alu_ctrl_fwd", 64'(alu_ctrl), 64'd3);
      check("t5_alu_x_fwd", alu_x, 64'd9);
`endif
      step();
      check("t5_rsp_valid", 64'(rsp_valid), 64'b01);
      check("t5_result", rsp_result, 64'd0);
      check("t5_zero", 64'(rsp_zero), 64'd1);
`ifdef ALU_ARB_OPCHECK_EN
      check("t5_err", 64'(rsp_err), 64'd1);
`else
      check("t5_err", 64'(rsp_err), 64'd0);
`endif
      rsp_ready = 2'b01;
      step();
      rsp_ready = 2'b00;

      // Legal OR afterwards clears the error flag: 3 | 4 = 7
      issue(0, 4'd1, 64'd3, 64'd4);
      step();
      check("t6_rsp_valid", 64'(rsp_valid), 64'b01);
      check("t6_result", rsp_result, 64'd7);
      check("t6_err", 64'(rsp_err), 64'd0);
      rsp_ready = 2'b01;
      step();
      rsp_ready = 2'b00;
      check("t6_idle", 64'(busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
